aifo_age_manager: RTL and testbench

AIFO_AGE_MANAGER -- requirements
Module: aifo_age_manager

---
 rtl/aifo_age_manager_nth_one_select.sv | 28 ++
 rtl/aifo_age_manager.sv | 177 +++++++++++++++++
 tb/tb_aifo_age_manager.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/aifo_age_manager_nth_one_select.sv
// nth_one_select: picks the (n+1)-th set bit of a vector, scanning from index 0.
//   vec_i    [W]  candidate bitmap (e.g. free slots)
//   n_i      [NW] zero-based rank of the set bit wanted
//   onehot_o [W]  one-hot of the selected bit, all zero if fewer than n+1 bits are set
module nth_one_select #(
  parameter int W  = 8,
  parameter int NW = 4
) (
  input  logic [W-1:0]  vec_i,
  input  logic [NW-1:0] n_i,
  output logic [W-1:0]  onehot_o
);

  // One extra bit so the running tally can never wrap back onto n_i.
  logic [NW:0] seen;

  always_comb begin
    seen     = '0;
    onehot_o = '0;
    for (int k = 0; k < W; k++) begin
      if (vec_i[k]) begin
        if (seen == {1'b0, n_i}) onehot_o[k] = 1'b1;
        seen = seen + (NW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/aifo_age_manager.sv
// aifo_age_manager: slot allocator with in-order release, tracked by an age matrix.
// Slots are allocated out of order (lowest free index first) and released in
// allocation order.
//   clk, rst        rising-edge clock, synchronous active-high reset
//   enq_vld_i/rdy_o per-lane allocate handshake
//   enq_mask_o/ptr_o slot offered to each enqueue lane (one-hot / binary)
//   deq_vld_o/rdy_i per-lane release handshake, lane i = i-th oldest entry
//   deq_mask_o/ptr_o slot of the i-th oldest entry (one-hot / binary)
//   flush_i         drop all entries
//   entry_vld_o     live-entry bitmap; count_o / empty_o / full_o occupancy
module aifo_age_manager #(
  parameter  int Depth    = 8,
  parameter  int EnqWidth = 2,
  parameter  int DeqWidth = 2,
  localparam int PtrWidth = $clog2(Depth),
  localparam int CntWidth = PtrWidth + 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [EnqWidth-1:0]                enq_vld_i,
  output logic [EnqWidth-1:0]                enq_rdy_o,
  output logic [EnqWidth-1:0][Depth-1:0]     enq_mask_o,
  output logic [EnqWidth-1:0][PtrWidth-1:0]  enq_ptr_o,
  output logic [DeqWidth-1:0]                deq_vld_o,
  input  logic [DeqWidth-1:0]                deq_rdy_i,
  output logic [DeqWidth-1:0][Depth-1:0]     deq_mask_o,
  output logic [DeqWidth-1:0][PtrWidth-1:0]  deq_ptr_o,
  input  logic                               flush_i,
  output logic [Depth-1:0]                   entry_vld_o,
  output logic [CntWidth-1:0]                count_o,
  output logic                               empty_o,
  output logic                               full_o
);

  // older_q[a][b] = 1 : slot a was allocated before slot b.
  logic [Depth-1:0]            valid_q, valid_d;
  logic [Depth-1:0][Depth-1:0] older_q, older_d;
  logic [CntWidth-1:0]         count_q, count_d;

  function automatic logic [PtrWidth-1:0] enc(input logic [Depth-1:0] oh);
    logic [PtrWidth-1:0] r;
    r = '0;
    for (int k = 0; k < Depth; k++) if (oh[k]) r = r | PtrWidth'(k);
    return r;
  endfunction

  // ---------------- enqueue ----------------
  logic [CntWidth-1:0]                free_cnt;
  logic [EnqWidth-1:0]                enq_fire;
  logic [EnqWidth-1:0][CntWidth-1:0]  enq_nth;
  logic [EnqWidth-1:0][Depth-1:0]     enq_sel;
  logic [CntWidth-1:0]                enq_n;

  assign free_cnt = CntWidth'(Depth) - count_q;

  always_comb begin
    enq_rdy_o = '0;
    for (int i = 0; i < EnqWidth; i++)
      enq_rdy_o[i] = (free_cnt > CntWidth'(i));
  end

  assign enq_fire = enq_vld_i & enq_rdy_o;

  // Rank for each lane = number of firing lanes below it, so a lane whose
  // neighbour stays idle slides down onto the lower free slot.
  always_comb begin
    logic [CntWidth-1:0] run;
    run     = '0;
    enq_nth = '0;
    for (int i = 0; i < EnqWidth; i++) begin
      enq_nth[i] = run;
      run        = run + CntWidth'(enq_fire[i]);
    end
    enq_n = run;
  end

  // Free set comes from start-of-cycle valid, so a slot released this cycle
  // is not handed out again until the next one.
  for (genvar g = 0; g < EnqWidth; g++) begin : g_enq
    nth_one_select #(.W(Depth), .NW(CntWidth)) u_sel (
      .vec_i    (~valid_q),
      .n_i      (enq_nth[g]),
      .onehot_o (enq_sel[g])
    );
    assign enq_mask_o[g] = enq_rdy_o[g] ? enq_sel[g] : '0;
    assign enq_ptr_o[g]  = enc(enq_mask_o[g]);
  end

  // ---------------- dequeue ----------------
  logic [Depth-1:0][CntWidth-1:0] rank;
  logic [DeqWidth-1:0]            deq_fire;
  logic [Depth-1:0]               deq_clr;
  logic [CntWidth-1:0]            deq_n;

  // rank[k] = number of live entries allocated before slot k.
  always_comb begin
    rank = '0;
    for (int k = 0; k < Depth; k++)
      for (int a = 0; a < Depth; a++)
        if (valid_q[a] && older_q[a][k]) rank[k] = rank[k] + CntWidth'(1);
  end

  always_comb begin
    deq_vld_o  = '0;
    deq_mask_o = '0;
    deq_ptr_o  = '0;
    for (int i = 0; i < DeqWidth; i++) begin
      deq_vld_o[i] = (count_q > CntWidth'(i));
      for (int k = 0; k < Depth; k++)
        deq_mask_o[i][k] = deq_vld_o[i] && valid_q[k] && (rank[k] == CntWidth'(i));
      deq_ptr_o[i] = enc(deq_mask_o[i]);
    end
  end

  // Release is an in-order prefix: a lane fires only if every lower lane fires.
  always_comb begin
    logic pfx;
    pfx      = 1'b1;
    deq_fire = '0;
    deq_clr  = '0;
    deq_n    = '0;
    for (int i = 0; i < DeqWidth; i++) begin
      pfx         = pfx & deq_vld_o[i] & deq_rdy_i[i];
      deq_fire[i] = pfx;
      if (pfx) begin
        deq_clr = deq_clr | deq_mask_o[i];
        deq_n   = deq_n + CntWidth'(1);
      end
    end
  end

  // ---------------- next state ----------------
  always_comb begin
    logic [Depth-1:0] lower;
    valid_d = valid_q & ~deq_clr;
    older_d = older_q;
    count_d = count_q + enq_n - deq_n;
    lower   = '0;
    // Lanes processed low to high: a later lane's row clear never disturbs
    // an earlier lane's column, and the column write marks earlier lanes older.
    for (int i = 0; i < EnqWidth; i++) begin
      if (enq_fire[i]) begin
        for (int k = 0; k < Depth; k++) begin
          if (enq_mask_o[i][k]) begin
            older_d[k] = '0;
            for (int a = 0; a < Depth; a++) older_d[a][k] = valid_q[a] | lower[a];
          end
        end
        valid_d = valid_d | enq_mask_o[i];
        lower   = lower | enq_mask_o[i];
      end
    end
    // Age matrix is left alone on flush; it is meaningless once valid is zero.
    if (flush_i) begin
      valid_d = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      older_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      older_q <= older_d;
      count_q <= count_d;
    end
  end

  assign entry_vld_o = valid_q;
  assign count_o     = count_q;
  assign empty_o     = (count_q == '0);
  assign full_o      = (count_q == CntWidth'(Depth));

endmodule

// File: tb/tb_aifo_age_manager.sv
// Directed bench for aifo_age_manager (Depth=8, 2 enqueue / 2 dequeue lanes).
module tb_aifo_age_manager;

  logic            clk;
  logic            rst;
  logic [1:0]      enq_vld;
  logic [1:0]      enq_rdy;
  logic [1:0][7:0] enq_mask;
  logic [1:0][2:0] enq_ptr;
  logic [1:0]      deq_vld;
  logic [1:0]      deq_rdy;
  logic [1:0][7:0] deq_mask;
  logic [1:0][2:0] deq_ptr;
  logic            flush;
  logic [7:0]      entry_vld;
  logic [3:0]      count;
  logic            empty;
  logic            full;

  int checks   = 0;
  int failures = 0;
  int order [7] = '{2, 3, 4, 5, 6, 7, 0};

  aifo_age_manager #(.Depth(8), .EnqWidth(2), .DeqWidth(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .enq_vld_i   (enq_vld),
    .enq_rdy_o   (enq_rdy),
    .enq_mask_o  (enq_mask),
    .enq_ptr_o   (enq_ptr),
    .deq_vld_o   (deq_vld),
    .deq_rdy_i   (deq_rdy),
    .deq_mask_o  (deq_mask),
    .deq_ptr_o   (deq_ptr),
    .flush_i     (flush),
    .entry_vld_o (entry_vld),
    .count_o     (count),
    .empty_o     (empty),
    .full_o      (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset overrides flush/enq/deq driven in the same cycles
    rst = 1'b1; enq_vld = 2'b11; deq_rdy = 2'b11; flush = 1'b1;
    tick(); tick();
    rst = 1'b0; enq_vld = 2'b00; deq_rdy = 2'b00; flush = 1'b0;
    #1;
    chk("rst_entry", entry_vld, 8'h00);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_deqvld", deq_vld, 2'b00);
    chk("rst_enqrdy", enq_rdy, 2'b11);

    // first allocation after reset
    enq_vld = 2'b11; #1;
    chk("enq0_ptr", enq_ptr[0], 0);
    chk("enq1_ptr", enq_ptr[1], 1);
    chk("enq1_mask", enq_mask[1], 8'h02);
    tick();
    enq_vld = 2'b00; deq_rdy = 2'b11; #1;
    chk("vis_count", count, 2);
    chk("vis_deqvld", deq_vld, 2'b11);
    chk("vis_deq0", deq_ptr[0], 0);
    chk("vis_deq1", deq_ptr[1], 1);

    // lane 1 ready without lane 0: nothing released
    deq_rdy = 2'b10;
    tick();
    deq_rdy = 2'b00; #1;
    chk("pfx_count", count, 2);
    chk("pfx_entry", entry_vld, 8'h03);

    // slot released this cycle is not reused this cycle
    deq_rdy = 2'b01; enq_vld = 2'b01; #1;
    chk("reuse_enq0", enq_ptr[0], 2);
    chk("reuse_deq0", deq_ptr[0], 0);
    tick();
    deq_rdy = 2'b00; enq_vld = 2'b00; #1;
    chk("reuse_entry", entry_vld, 8'h06);
    chk("reuse_count", count, 2);

    // flush wins over same-cycle enq and deq
    enq_vld = 2'b11; deq_rdy = 2'b11; flush = 1'b1;
    tick();
    enq_vld = 2'b00; deq_rdy = 2'b00; flush = 1'b0; #1;
    chk("flush_count", count, 0);
    chk("flush_empty", empty, 1);
    chk("flush_entry", entry_vld, 8'h00);

    // fill to full
    enq_vld = 2'b11;
    repeat (4) tick();
    enq_vld = 2'b00; #1;
    chk("full_count", count, 8);
    chk("full_flag", full, 1);
    chk("full_enqrdy", enq_rdy, 2'b00);
    chk("full_entry", entry_vld, 8'hFF);

    // full: dequeue two with both enq lanes requesting
    enq_vld = 2'b11; deq_rdy = 2'b11; #1;
    chk("full_deq0", deq_ptr[0], 0);
    chk("full_deq1", deq_ptr[1], 1);
    chk("full_enqmask0", enq_mask[0], 8'h00);
    tick();
    enq_vld = 2'b00; deq_rdy = 2'b00; #1;
    chk("fdeq_count", count, 6);
    chk("fdeq_entry", entry_vld, 8'hFC);
    chk("fdeq_full", full, 0);

    // new entry lands in slot 0 but releases last
    enq_vld = 2'b01; #1;
    chk("ooo_enq0", enq_ptr[0], 0);
    tick();
    enq_vld = 2'b00; deq_rdy = 2'b01;
    for (int i = 0; i < 7; i++) begin
      #1;
      chk($sformatf("ooo_order%0d", i), deq_ptr[0], order[i]);
      tick();
    end
    deq_rdy = 2'b00; #1;
    chk("drain_empty", empty, 1);

    // leave only slots 6,7 live, then enqueue on lane 1 only
    enq_vld = 2'b11;
    repeat (4) tick();
    enq_vld = 2'b00; deq_rdy = 2'b11;
    repeat (3) tick();
    deq_rdy = 2'b00; #1;
    chk("gap_entry0", entry_vld, 8'hC0);
    enq_vld = 2'b10; #1;
    chk("gap_enqrdy", enq_rdy, 2'b11);
    chk("gap_enq1", enq_ptr[1], 0);
    chk("gap_mask1", enq_mask[1], 8'h01);
    tick();
    enq_vld = 2'b00; deq_rdy = 2'b11; #1;
    chk("gap_entry1", entry_vld, 8'hC1);
    chk("gap_deq0", deq_ptr[0], 6);
    chk("gap_deq1", deq_ptr[1], 7);
    deq_rdy = 2'b00;

    // reset mid-operation discards everything
    rst = 1'b1; enq_vld = 2'b11;
    tick();
    rst = 1'b0; enq_vld = 2'b00; #1;
    chk("mrst_count", count, 0);
    chk("mrst_entry", entry_vld, 8'h00);
    chk("mrst_enqrdy", enq_rdy, 2'b11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
